// File: rtl/axi_vdma_pkg.sv
// Shared AXI constants and the read burst engine state type.
package axi_vdma_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned MAX_BEATS = 256;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/axi_read_burst_engine.sv
// AXI4 read burst engine: acknowledges FIFO burst/tail requests, issues one
// AR at a time (max 256 beats each) from the frame buffer, pushes R beats
// into the read FIFO and pulses done. Owns the frame read address pointer.
// Optional feature macro: AXI_RRESP_CHK_EN (sticky rd_err on SLVERR/DECERR).
module axi_read_burst_engine
  import axi_vdma_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DATA_W      = 64,
  parameter int unsigned        ID_W        = 4,
  parameter int unsigned        LSIZE       = 9,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter int unsigned        FRAME_BYTES = 2073600,
  parameter logic [ID_W-1:0]    ARID_VAL    = '0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              fsync,
  input  logic              burst_req,
  input  logic              tail_req,
  input  logic [LSIZE-1:0]  req_len,
  output logic              resp,
  output logic              done,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid,
  input  logic              rvalid,
  output logic              rready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_full,
  output logic              rd_err
);

  localparam int unsigned       BPB       = DATA_W / 8;
  localparam int unsigned       BPB_LOG   = $clog2(BPB);
  localparam logic [ADDR_W-1:0] FRAME_END = BASE_ADDR + ADDR_W'(FRAME_BYTES);

  rd_state_t          st;
  logic [LSIZE-1:0]   remain;
  logic [CNT_W-1:0]   chunk;
  logic [CNT_W-1:0]   cur_chunk;
  logic [CNT_W-1:0]   beat_cnt;
  logic [ADDR_W-1:0]  addr_ptr;
  logic [ADDR_W-1:0]  ptr_sum;
  logic [ADDR_W-1:0]  ptr_next;
  logic               fsync_pend;
  logic               beat;
  logic               unused_inputs;

  assign arsize       = 3'(BPB_LOG);
  assign arburst      = AXI_BURST_INCR;
  assign arid         = ARID_VAL;
  assign rready       = (st == ST_DATA) && !fifo_full;
  assign beat         = rvalid && rready;
  assign fifo_wr_en   = beat;
  assign fifo_wr_data = rdata;

  // rlast and rid carry no control meaning: the beat counter is authoritative
  assign unused_inputs = ^{rlast, rid, rresp};

  // Next burst size and the wrapped pointer after the current burst
  always_comb begin
    chunk    = (32'(remain) > MAX_BEATS) ? CNT_W'(MAX_BEATS) : CNT_W'(remain);
    ptr_sum  = addr_ptr + (ADDR_W'(cur_chunk) << BPB_LOG);
    ptr_next = (ptr_sum >= FRAME_END) ? BASE_ADDR : ptr_sum;
  end

  // Request handshake, AR issue, beat counting and address pointer FSM
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      resp       <= 1'b0;
      done       <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      remain     <= '0;
      cur_chunk  <= '0;
      beat_cnt   <= '0;
      addr_ptr   <= BASE_ADDR;
      fsync_pend <= 1'b0;
    end else begin
      resp <= 1'b0;
      done <= 1'b0;
      if (fsync && st != ST_IDLE) fsync_pend <= 1'b1;
      case (st)
        ST_IDLE: begin
          // fsync takes this cycle; a held request is served on the next one
          if (fsync) begin
            addr_ptr <= BASE_ADDR;
          end else if (burst_req || tail_req) begin
            remain <= req_len;
            st     <= ST_ACK;
          end
        end
        ST_ACK: begin
          resp <= 1'b1;
          st   <= (remain == '0) ? ST_DONE : ST_ADDR;
        end
        ST_ADDR: begin
          // First cycle loads the AR fields, which then stay frozen until arready
          if (!arvalid) begin
            arvalid   <= 1'b1;
            araddr    <= addr_ptr;
            arlen     <= 8'(chunk - 1'b1);
            cur_chunk <= chunk;
          end else if (arready) begin
            arvalid  <= 1'b0;
            beat_cnt <= cur_chunk;
            st       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == CNT_W'(1)) begin
              remain   <= remain - LSIZE'(cur_chunk);
              addr_ptr <= ptr_next;
              st       <= (remain == LSIZE'(cur_chunk)) ? ST_DONE : ST_ADDR;
            end
          end
        end
        ST_DONE: begin
          done <= 1'b1;
          st   <= ST_IDLE;
          // A frame start seen during the transfer overrides its pointer update
          if (fsync_pend || fsync) begin
            addr_ptr   <= BASE_ADDR;
            fsync_pend <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI_RRESP_CHK_EN
  logic err_q;

  // Sticky error on any accepted SLVERR/DECERR beat; cleared by fsync in IDLE
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (st == ST_IDLE && fsync) begin
      err_q <= 1'b0;
    end else if (beat && (rresp == AXI_RESP_SLVERR || rresp == AXI_RESP_DECERR)) begin
      err_q <= 1'b1;
    end
  end

  assign rd_err = err_q;
`else
  assign rd_err = 1'b0;
`endif

endmodule
